// File: rtl/mul_column_acc_if.sv
// mul_column_acc_if: request/result handshake bundle for the column-sum engine
interface mul_column_acc_if #(parameter int NBYTES = 4);
  localparam int CW = $clog2(2*NBYTES);
  localparam int SUMW = 16 + $clog2(NBYTES);
  logic [16*NBYTES-1:0] i_msg;
  logic [CW-1:0] i_col;
  logic i_valid;
  logic o_ready;
  logic [SUMW-1:0] o_sum;
  logic o_err;
  logic o_valid;
  logic i_ready;
  modport slave(input i_msg, i_col, i_valid, i_ready, output o_ready, o_sum, o_err, o_valid);
  modport master(output i_msg, i_col, i_valid, i_ready, input o_ready, o_sum, o_err, o_valid);
endinterface

// File: rtl/mul_column_acc.sv
// mul_column_acc: sequential diagonal byte-product column sum using LANES 8x8 multipliers
module mul_column_acc #(
  parameter int NBYTES = 4,
  parameter int LANES = 1
) (
  input logic clk,
  input logic rstn,
  mul_column_acc_if.slave bus
);
  localparam int CW = $clog2(2*NBYTES);
  localparam int SUMW = 16 + $clog2(NBYTES);
  localparam int IW = CW + 1;
  localparam int BW = $clog2(NBYTES);
  typedef enum logic [1:0] {IDLE, ACC, DONE} state_t;
  state_t state_q, state_d;
  logic [8*NBYTES-1:0] a_q, a_d, b_q, b_d;
  logic [IW-1:0] col_q, col_d, idx_q, idx_d, hi_q, hi_d;
  logic [SUMW-1:0] acc_q, acc_d, lane_sum;
  logic err_q, err_d;
  logic [IW-1:0] col_in, ii, jj;
  logic [15:0] prod;
  assign col_in = IW'(bus.i_col);
  // sum of this cycle's lane products; lanes beyond the column's last row contribute nothing
  always_comb begin
    lane_sum = '0;
    ii = '0;
    jj = '0;
    prod = '0;
    for (int k = 0; k < LANES; k++) begin
      ii = idx_q + IW'(k);
      jj = col_q - ii;
      prod = (ii <= hi_q) ? 16'(a_q[8*ii[BW-1:0] +: 8]) * 16'(b_q[8*jj[BW-1:0] +: 8]) : 16'd0;
      lane_sum = lane_sum + SUMW'(prod);
    end
  end
  // job sequencing: accept in IDLE, accumulate in ACC, hold the result in DONE until taken
  always_comb begin
    state_d = state_q;
    a_d = a_q;
    b_d = b_q;
    col_d = col_q;
    idx_d = idx_q;
    hi_d = hi_q;
    acc_d = acc_q;
    err_d = err_q;
    case (state_q)
      IDLE: if (bus.i_valid) begin
        a_d = bus.i_msg[8*NBYTES-1:0];
        b_d = bus.i_msg[16*NBYTES-1:8*NBYTES];
        col_d = col_in;
        acc_d = '0;
        idx_d = (col_in > IW'(NBYTES-1)) ? col_in - IW'(NBYTES-1) : '0;
        hi_d = (col_in < IW'(NBYTES-1)) ? col_in : IW'(NBYTES-1);
        err_d = col_in > IW'(2*NBYTES-2);
        state_d = err_d ? DONE : ACC;
      end
      ACC: begin
        acc_d = acc_q + lane_sum;
        idx_d = idx_q + IW'(LANES);
        state_d = (idx_q + IW'(LANES) > hi_q) ? DONE : ACC;
      end
      DONE: if (bus.i_ready) begin
        err_d = 1'b0;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end
  // state and datapath registers, cleared asynchronously so a reset drops any job in flight
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state_q <= IDLE;
      a_q <= '0;
      b_q <= '0;
      col_q <= '0;
      idx_q <= '0;
      hi_q <= '0;
      acc_q <= '0;
      err_q <= 1'b0;
    end else begin
      state_q <= state_d;
      a_q <= a_d;
      b_q <= b_d;
      col_q <= col_d;
      idx_q <= idx_d;
      hi_q <= hi_d;
      acc_q <= acc_d;
      err_q <= err_d;
    end
  end
  assign bus.o_ready = state_q == IDLE;
  assign bus.o_valid = state_q == DONE;
  assign bus.o_sum = acc_q;
  assign bus.o_err = err_q;
endmodule

// File: tb/tb_mul_column_acc.sv
// tb_mul_column_acc: table and scoreboard checks of the column-sum engine at LANES=1 and LANES=2
module tb_mul_column_acc;
  localparam int NB = 4;
  localparam int CW = 3;
  localparam int SW = 18;
  logic clk = 0, rstn = 0, vld = 0, rdy = 1;
  logic [16*NB-1:0] msg = '0;
  logic [CW-1:0] col = '0;
  int cyc = 0;
  int tests = 0, fails = 0;
  always #5 clk = ~clk;
  always @(posedge clk) cyc++;
  mul_column_acc_if #(.NBYTES(NB)) bus1();
  mul_column_acc_if #(.NBYTES(NB)) bus2();
  assign bus1.i_msg = msg;
  assign bus1.i_col = col;
  assign bus1.i_valid = vld;
  assign bus1.i_ready = rdy;
  assign bus2.i_msg = msg;
  assign bus2.i_col = col;
  assign bus2.i_valid = vld;
  assign bus2.i_ready = rdy;
  mul_column_acc #(.NBYTES(NB), .LANES(1)) dut1(.clk(clk), .rstn(rstn), .bus(bus1));
  mul_column_acc #(.NBYTES(NB), .LANES(2)) dut2(.clk(clk), .rstn(rstn), .bus(bus2));
  typedef struct {logic [SW-1:0] sum; logic err; int lat;} exp_t;
  typedef struct {logic [31:0] a; logic [31:0] b; int c; logic [SW-1:0] sum; logic err;} vec_t;
  exp_t q1[$], q2[$];
  vec_t tbl[9];
  task automatic chk(input string nm, input longint act, input longint req);
    tests++;
    if (act !== req) begin
      fails++;
      $display("FAIL %s actual=%0h required=%0h", nm, act, req);
    end
  endtask
  function automatic void model(input logic [31:0] a, input logic [31:0] b, input int c, output logic [SW-1:0] s, output int n);
    s = '0;
    n = 0;
    for (int i = 0; i < NB; i++)
      for (int j = 0; j < NB; j++)
        if (i + j == c) begin
          s = s + SW'(a[8*i +: 8]) * SW'(b[8*j +: 8]);
          n++;
        end
  endfunction
  task automatic score(input string tag, input exp_t e, input logic [SW-1:0] s, input logic er, input int lat);
    chk({tag, " sum"}, s, e.sum);
    chk({tag, " err"}, er, e.err);
    chk({tag, " latency"}, lat, e.lat);
  endtask
  int acc1, acc2, lat1, lat2;
  logic pv1 = 0, pv2 = 0;
  exp_t e1, e2;
  always @(negedge clk) begin
    if (!rstn) pv1 = 0;
    else begin
      if (bus1.i_valid && bus1.o_ready) acc1 = cyc + 1;
      if (bus1.o_valid && !pv1) lat1 = cyc - acc1;
      pv1 = bus1.o_valid;
      if (bus1.o_valid && bus1.i_ready) begin
        if (q1.size() == 0) begin
          tests++; fails++;
          $display("FAIL L1 unexpected result sum=%0h", bus1.o_sum);
        end else begin
          e1 = q1.pop_front();
          score("L1", e1, bus1.o_sum, bus1.o_err, lat1);
        end
      end
    end
  end
  always @(negedge clk) begin
    if (!rstn) pv2 = 0;
    else begin
      if (bus2.i_valid && bus2.o_ready) acc2 = cyc + 1;
      if (bus2.o_valid && !pv2) lat2 = cyc - acc2;
      pv2 = bus2.o_valid;
      if (bus2.o_valid && bus2.i_ready) begin
        if (q2.size() == 0) begin
          tests++; fails++;
          $display("FAIL L2 unexpected result sum=%0h", bus2.o_sum);
        end else begin
          e2 = q2.pop_front();
          score("L2", e2, bus2.o_sum, bus2.o_err, lat2);
        end
      end
    end
  end
  task automatic push(input logic [31:0] a, input logic [31:0] b, input int c, input logic [SW-1:0] xs, input logic xe);
    logic [SW-1:0] ms;
    int n;
    model(a, b, c, ms, n);
    q1.push_back('{sum: xs, err: xe, lat: xe ? 0 : n});
    q2.push_back('{sum: xs, err: xe, lat: xe ? 0 : (n + 1) / 2});
  endtask
  task automatic drive(input logic [31:0] a, input logic [31:0] b, input int c);
    msg = {b, a};
    col = CW'(c);
    vld = 1;
    @(posedge clk); #1;
    vld = 0;
    msg = {$urandom, $urandom};
    col = CW'($urandom);
  endtask
  task automatic issue(input logic [31:0] a, input logic [31:0] b, input int c, input logic [SW-1:0] xs, input logic xe, input bit doexp);
    @(posedge clk); #1;
    if (doexp) push(a, b, c, xs, xe);
    drive(a, b, c);
  endtask
  task automatic wait_idle(input string nm);
    int n = 0;
    while (!(bus1.o_ready && bus2.o_ready && q1.size() == 0 && q2.size() == 0) && n < 100) begin
      @(posedge clk); #1;
      n++;
    end
    if (n >= 100) begin
      tests++; fails++;
      $display("FAIL %s timeout q1=%0d q2=%0d", nm, q1.size(), q2.size());
      q1.delete();
      q2.delete();
    end
  endtask
  initial begin
    #300000;
    $display("FAIL watchdog expired");
    $fatal(1, "watchdog");
  end
  initial begin
    logic [31:0] ra, rb;
    logic [SW-1:0] ms, held;
    int rc, n;
    tbl[0] = '{32'h04030201, 32'h08070605, 3, 18'h3C, 1'b0};
    tbl[1] = '{32'h04030201, 32'h08070605, 0, 18'h05, 1'b0};
    tbl[2] = '{32'h04030201, 32'h08070605, 6, 18'h20, 1'b0};
    tbl[3] = '{32'h04030201, 32'h08070605, 1, 18'h10, 1'b0};
    tbl[4] = '{32'h04030201, 32'h08070605, 2, 18'h22, 1'b0};
    tbl[5] = '{32'h04030201, 32'h08070605, 4, 18'h3D, 1'b0};
    tbl[6] = '{32'h04030201, 32'h08070605, 5, 18'h34, 1'b0};
    tbl[7] = '{32'hFFFFFFFF, 32'hFFFFFFFF, 3, 18'h3F804, 1'b0};
    tbl[8] = '{32'h04030201, 32'h08070605, 7, 18'h0, 1'b1};
    repeat (2) @(posedge clk);
    #1;
    chk("reset o_ready", bus1.o_ready, 1);
    chk("reset o_valid", bus1.o_valid, 0);
    chk("reset o_sum", bus1.o_sum, 0);
    chk("reset o_err", bus1.o_err, 0);
    chk("reset L2 o_ready", bus2.o_ready, 1);
    rstn = 1;
    foreach (tbl[t]) begin
      issue(tbl[t].a, tbl[t].b, tbl[t].c, tbl[t].sum, tbl[t].err, 1);
      wait_idle("table");
      chk("after o_valid", bus1.o_valid, 0);
      chk("after o_err", bus1.o_err, 0);
      chk("after o_sum kept", bus1.o_sum, tbl[t].sum);
    end
    for (int r = 0; r < 6; r++) begin
      ra = $urandom;
      rb = $urandom;
      rc = $urandom_range(0, 7);
      model(ra, rb, rc, ms, n);
      issue(ra, rb, rc, (rc > 6) ? '0 : ms, rc > 6, 1);
      wait_idle("random");
    end
    rdy = 0;
    issue(32'h04030201, 32'h08070605, 3, 18'h3C, 1'b0, 1);
    n = 0;
    while (!(bus1.o_valid && bus2.o_valid) && n < 20) begin
      @(posedge clk); #1;
      n++;
    end
    chk("stall reached DONE", bus1.o_valid, 1);
    held = bus1.o_sum;
    chk("stall held sum", held, 18'h3C);
    for (int s = 0; s < 10; s++) begin
      @(posedge clk); #1;
      vld = s[0];
      msg = {$urandom, $urandom};
      col = CW'($urandom);
      @(negedge clk);
      chk("stall o_sum", bus1.o_sum, held);
      chk("stall o_ready", bus1.o_ready, 0);
      chk("stall o_valid", bus1.o_valid, 1);
    end
    @(posedge clk); #1;
    vld = 0;
    rdy = 1;
    @(posedge clk); #1;
    chk("post-stall o_ready", bus1.o_ready, 1);
    push(32'h01010101, 32'h01010101, 3, 18'h4, 1'b0);
    drive(32'h01010101, 32'h01010101, 3);
    chk("next job accepted", bus1.o_ready, 0);
    wait_idle("post-stall");
    issue(32'h04030201, 32'h08070605, 3, 18'h0, 1'b0, 0);
    @(posedge clk); #1;
    rstn = 0;
    #1;
    chk("async rst o_valid", bus1.o_valid, 0);
    chk("async rst o_sum", bus1.o_sum, 0);
    chk("async rst o_ready", bus1.o_ready, 1);
    chk("async rst L2 o_sum", bus2.o_sum, 0);
    repeat (2) @(posedge clk);
    #1;
    rstn = 1;
    chk("post-rst o_ready", bus1.o_ready, 1);
    issue(32'h04030201, 32'h08070605, 3, 18'h3C, 1'b0, 1);
    wait_idle("post-rst");
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
